// File: rtl/online_adder_hd_pkg.sv
// Shared definitions for the radix-2 online signed-digit adder.
// Digit code: bit1 = plus, bit0 = minus. 10 = +1, 01 = -1, 00 = 0.
// The code 11 is accepted on inputs and read as 0, but it is never produced.
package online_adder_hd_pkg;

  localparam logic [1:0] DIG_POS  = 2'b10;
  localparam logic [1:0] DIG_NEG  = 2'b01;
  localparam logic [1:0] DIG_ZERO = 2'b00;

  // Digit code -> signed value in {-1, 0, +1}. The code 11 maps to 0.
  function automatic logic signed [1:0] dig_to_val(input logic [1:0] d);
    logic signed [1:0] v;
    v = 2'sb00;
    case (d)
      DIG_POS: v = 2'sb01;
      DIG_NEG: v = 2'sb11;
      default: v = 2'sb00;
    endcase
    return v;
  endfunction

  // Signed value in {-1, 0, +1} -> digit code. Zero is always encoded as 00.
  function automatic logic [1:0] val_to_dig(input logic signed [1:0] v);
    logic [1:0] d;
    d = DIG_ZERO;
    if (v == 2'sb01)      d = DIG_POS;
    else if (v == 2'sb11) d = DIG_NEG;
    return d;
  endfunction

endpackage

// File: rtl/online_adder_hd_sd_transfer_select.sv
// Transfer/interim selection for one digit position of the online adder.
// Ports:
//   w_j_i  : position sum w_j in -2..2 (3-bit two's complement)
//   w_j1_i : lookahead position sum w_{j+1}
//   t_o    : transfer digit t_j in {-1, 0, +1}
//   v_o    : interim digit v_j in {-1, 0, +1}
module sd_transfer_select
  import online_adder_hd_pkg::*;
(
  input  logic signed [2:0] w_j_i,
  input  logic signed [2:0] w_j1_i,
  output logic signed [1:0] t_o,
  output logic signed [1:0] v_o
);

  always_comb begin
    t_o = 2'sb00;
    v_o = 2'sb00;
    case (w_j_i)
      3'sb010: t_o = 2'sb01;
      3'sb110: t_o = 2'sb11;
      // For |w| = 1 the lookahead decides whether to carry now, so that
      // v_j + t_{j+1} can never reach +/-2.
      3'sb001: begin
        if (w_j1_i >= 3'sb001) begin
          t_o = 2'sb01;
          v_o = 2'sb11;
        end else begin
          v_o = 2'sb01;
        end
      end
      3'sb111: begin
        if (w_j1_i <= 3'sb111) begin
          t_o = 2'sb11;
          v_o = 2'sb01;
        end else begin
          v_o = 2'sb11;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/online_adder_hd.sv
// Radix-2 online (MSD-first) signed-digit adder, online delay 2.
// One digit of X and Y enters per cycle; one digit of Z = X + Y leaves per
// cycle, registered. z_0 (the integer digit) appears after the 2nd edge
// following reset release.
// Ports:
//   x_in       : digit of operand X (signed-digit code)
//   y_in       : digit of operand Y (signed-digit code)
//   clk        : clock, rising edge
//   data_out   : digit of sum Z, registered, never 11
//   asyn_reset : asynchronous active-high reset, clears all state
module online_adder_hd
  import online_adder_hd_pkg::*;
(
  input  logic [1:0] x_in,
  input  logic [1:0] y_in,
  input  logic       clk,
  output logic [1:0] data_out,
  input  logic       asyn_reset
);

  logic signed [1:0] x_val, y_val;
  logic signed [2:0] w_live;       // w_{j+2}
  logic signed [2:0] w1_q, w1_d;   // w_j
  logic signed [2:0] w2_q, w2_d;   // w_{j+1}
  logic signed [1:0] t_j, v_j, t_j1, v_j1;
  logic signed [1:0] z_val;
  logic [1:0]        dout_q, dout_d;

  assign x_val  = dig_to_val(x_in);
  assign y_val  = dig_to_val(y_in);
  assign w_live = {x_val[1], x_val} + {y_val[1], y_val};

  // Interim digit for position j.
  sd_transfer_select u_sel_j (
    .w_j_i  (w1_q),
    .w_j1_i (w2_q),
    .t_o    (t_j),
    .v_o    (v_j)
  );

  // Transfer into position j from position j+1.
  sd_transfer_select u_sel_j1 (
    .w_j_i  (w2_q),
    .w_j1_i (w_live),
    .t_o    (t_j1),
    .v_o    (v_j1)
  );

  // The lookahead guarantees z_j lies in {-1, 0, +1}, so 2-bit arithmetic
  // cannot wrap.
  assign z_val  = v_j + t_j1;
  assign dout_d = val_to_dig(z_val);
  assign w1_d   = w2_q;
  assign w2_d   = w_live;

  always_ff @(posedge clk or posedge asyn_reset) begin
    if (asyn_reset) begin
      w1_q   <= 3'sb000;
      w2_q   <= 3'sb000;
      dout_q <= DIG_ZERO;
    end else begin
      w1_q   <= w1_d;
      w2_q   <= w2_d;
      dout_q <= dout_d;
    end
  end

  assign data_out = dout_q;

endmodule

// File: tb/tb_online_adder_hd.sv
module tb_online_adder_hd;

  logic       clk = 1'b0;
  logic       asyn_reset;
  logic [1:0] x_in, y_in;
  logic [1:0] data_out;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  online_adder_hd dut (
    .x_in       (x_in),
    .y_in       (y_in),
    .clk        (clk),
    .data_out   (data_out),
    .asyn_reset (asyn_reset)
  );

  function automatic int dv(input logic [1:0] d);
    case (d)
      2'b10:   return 1;
      2'b01:   return -1;
      default: return 0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Hold reset over two edges, check the cleared output, release between
  // edges so the next rising edge is E_1.
  task automatic do_reset();
    asyn_reset = 1'b1;
    x_in = 2'b00;
    y_in = 2'b00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_out", data_out, 2'b00);
    asyn_reset = 1'b0;
  endtask

  // Present one digit pair, take the edge, sample just after it.
  task automatic step(input logic [1:0] x, input logic [1:0] y);
    x_in = x;
    y_in = y;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int ex, acc;
    logic [1:0] xd, yd;

    asyn_reset = 1'b1;
    x_in = 2'b00;
    y_in = 2'b00;

    // Test 1: 0.75 + 0.5 = 1.25
    do_reset();
    step(2'b10, 2'b10); check("t1_e1", data_out, 2'b00);
    step(2'b10, 2'b00); check("t1_e2", data_out, 2'b10);
    step(2'b00, 2'b00); check("t1_e3", data_out, 2'b00);
    step(2'b00, 2'b00); check("t1_e4", data_out, 2'b10);
    step(2'b00, 2'b00); check("t1_e5", data_out, 2'b00);

    // Test 2: 0.9375 + 0.9375 = 1.875
    do_reset();
    step(2'b10, 2'b10); check("t2_e1", data_out, 2'b00);
    step(2'b10, 2'b10); check("t2_e2", data_out, 2'b10);
    step(2'b10, 2'b10); check("t2_e3", data_out, 2'b10);
    step(2'b10, 2'b10); check("t2_e4", data_out, 2'b10);
    step(2'b00, 2'b00); check("t2_e5", data_out, 2'b10);
    step(2'b00, 2'b00); check("t2_e6", data_out, 2'b00);

    // Test 3: 0.5 + (-0.125) = 0.375
    do_reset();
    step(2'b10, 2'b00); check("t3_e1", data_out, 2'b00);
    step(2'b00, 2'b00); check("t3_e2", data_out, 2'b00);
    step(2'b00, 2'b01); check("t3_e3", data_out, 2'b10);
    step(2'b00, 2'b00); check("t3_e4", data_out, 2'b00);
    step(2'b00, 2'b00); check("t3_e5", data_out, 2'b01);

    // Test 4: X = -Y, output stays zero
    do_reset();
    step(2'b10, 2'b01); check("t4_e1", data_out, 2'b00);
    step(2'b10, 2'b01); check("t4_e2", data_out, 2'b00);
    step(2'b10, 2'b01); check("t4_e3", data_out, 2'b00);
    step(2'b00, 2'b00); check("t4_e4", data_out, 2'b00);
    step(2'b00, 2'b00); check("t4_e5", data_out, 2'b00);

    // Test 5: asynchronous reset mid-stream, then replay Test 1
    do_reset();
    step(2'b10, 2'b10);
    step(2'b10, 2'b10);
    step(2'b10, 2'b10); check("t5_pre_rst", data_out, 2'b10);
    #1 asyn_reset = 1'b1;
    #1 check("t5_async_clr", data_out, 2'b00);
    @(posedge clk);
    #1 check("t5_rst_dominates", data_out, 2'b00);
    @(negedge clk);
    asyn_reset = 1'b0;
    step(2'b10, 2'b10); check("t5_e1", data_out, 2'b00);
    step(2'b10, 2'b00); check("t5_e2", data_out, 2'b10);
    step(2'b00, 2'b00); check("t5_e3", data_out, 2'b00);
    step(2'b00, 2'b00); check("t5_e4", data_out, 2'b10);
    step(2'b00, 2'b00); check("t5_e5", data_out, 2'b00);

    // Test 6: random 16-digit streams including 11 codes; values scaled by 2^16
    for (int s = 0; s < 4; s++) begin
      do_reset();
      ex  = 0;
      acc = 0;
      for (int k = 1; k <= 18; k++) begin
        if (k <= 16) begin
          xd = 2'($urandom_range(0, 3));
          yd = 2'($urandom_range(0, 3));
          if (k == 3) xd = 2'b11;
          if (k == 5) yd = 2'b11;
          ex += (dv(xd) + dv(yd)) * (1 << (16 - k));
        end else begin
          xd = 2'b00;
          yd = 2'b00;
        end
        step(xd, yd);
        if (k >= 2) begin
          n_cmp++;
          assert (data_out inside {2'b00, 2'b10, 2'b01}) else begin
            n_bad++;
            $error("FAIL t6_legal: observed %b expected one of 00/10/01", data_out);
          end
          acc += dv(data_out) * (1 << (16 - (k - 2)));
        end
      end
      n_cmp++;
      assert (acc == ex) else begin
        n_bad++;
        $error("FAIL t6_value: observed %0d expected %0d (x 2^-16)", acc, ex);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
